jtframe_sdram_responder: RTL and testbench

- Cycle-level responder for the 16-bit SDR SDRAM pin interface driven by jtframe_sdram64 in simulation test harnesses.
- Decodes controller commands, tracks the open row of each of the 4 banks, and serves read/write bursts from an internal word array with CAS latency and DQM timing.
- Flags protocol violations so benches can catch controller bugs without a vendor chip model.

---
 rtl/jtframe_sdram_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_jtframe_sdram_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_sdram_responder.sv
// Behavioural SDR SDRAM responder for jtframe_sdram64 test harnesses.
// Decodes commands, tracks open rows per bank, serves bursts from an internal
// word array with CAS latency / DQM timing and latches protocol violations.
module jtframe_sdram_responder #(
   parameter int ROWW = 13,
   parameter int COLW = 9
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        sdram_cke,
   input  logic        sdram_ncs,
   input  logic        sdram_nras,
   input  logic        sdram_ncas,
   input  logic        sdram_nwe,
   input  logic [1:0]  sdram_ba,
   input  logic [12:0] sdram_a,
   input  logic        sdram_dqml,
   input  logic        sdram_dqmh,
   input  logic [15:0] sdram_din,
   output logic [15:0] sdram_dout,
   output logic [1:0]  sdram_dq_oe,
   output logic        err,
   output logic [2:0]  err_code
);
   localparam int AW = 2 + ROWW + COLW;

   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_MRS = 3'b000;
   localparam logic [2:0] CMD_BST = 3'b110;

   logic [15:0] mem [0:(1<<AW)-1];

   // mode register
   logic [1:0]  bl_code;           // burst length = 1 << bl_code
   logic        cl3;               // 1: CL3, 0: CL2
   logic        wsingle;           // single-location writes
   // bank state
   logic [3:0]      bank_open;
   logic [3:0]      act_recent;    // bank activated on the previous enabled edge
   logic [ROWW-1:0] bank_row [4];
   // burst in progress (beats still to be issued)
   logic            b_act, b_wr, b_ap;
   logic [1:0]      b_bank;
   logic [ROWW-1:0] b_row;
   logic [COLW-1:0] b_col;
   logic [2:0]      b_k, b_last;
   // read pipeline: stage 1 is registered to dout on the next edge
   logic [2:1]      pv;
   logic [AW-1:0]   pa1, pa2;
   logic [1:0]      dqm_d;         // DQM from previous edge masks the beat being registered

   logic [2:0]      cmd;
   logic            is_rd, is_wr, cancel, start;
   logic [2:0]      bl_m1;
   logic            iss, iss_wr, iss_ap, iss_last;
   logic [1:0]      iss_bank;
   logic [ROWW-1:0] iss_row;
   logic [COLW-1:0] iss_col, col_mask, beat_col;
   logic [2:0]      iss_k, iss_lastk;
   logic [AW-1:0]   beat_addr;

   assign cmd    = sdram_ncs ? CMD_NOP : {sdram_nras, sdram_ncas, sdram_nwe};
   assign is_rd  = cmd == CMD_RD;
   assign is_wr  = cmd == CMD_WR;
   // commands that stop the remaining beats of a burst, including this edge's beat
   assign cancel = is_rd | is_wr | (cmd == CMD_BST) |
                   ((cmd == CMD_PRE) & (sdram_a[10] | (sdram_ba == b_bank)));
   assign start  = (is_rd | is_wr) & bank_open[sdram_ba];

   // burst length minus one from the mode code
   always_comb begin
      bl_m1 = 3'd0;
      case (bl_code)
         2'd1:    bl_m1 = 3'd1;
         2'd2:    bl_m1 = 3'd3;
         2'd3:    bl_m1 = 3'd7;
         default: bl_m1 = 3'd0;
      endcase
   end

   // select the beat issued on this edge: a new command's beat 0 or the ongoing burst's next beat
   always_comb begin
      iss       = 1'b0;
      iss_wr    = b_wr;
      iss_ap    = b_ap;
      iss_bank  = b_bank;
      iss_row   = b_row;
      iss_col   = b_col;
      iss_k     = b_k;
      iss_lastk = b_last;
      if (start) begin
         iss       = 1'b1;
         iss_wr    = is_wr;
         iss_ap    = sdram_a[10];
         iss_bank  = sdram_ba;
         iss_row   = bank_row[sdram_ba];
         iss_col   = sdram_a[COLW-1:0];
         iss_k     = 3'd0;
         iss_lastk = (is_wr && wsingle) ? 3'd0 : bl_m1;
      end else if (b_act && !cancel) begin
         iss = 1'b1;
      end
   end

   // beats wrap inside the BL-aligned block of columns
   assign col_mask  = COLW'(iss_lastk);
   assign beat_col  = (iss_col & ~col_mask) | ((iss_col + COLW'(iss_k)) & col_mask);
   assign beat_addr = {iss_bank, iss_row, beat_col};
   assign iss_last  = iss_k == iss_lastk;

   // array write with zero-latency byte masks; contents are never reset
   always_ff @(posedge clk) begin
      if (sdram_cke && iss && iss_wr) begin
         if (!sdram_dqml) mem[beat_addr][7:0]  <= sdram_din[7:0];
         if (!sdram_dqmh) mem[beat_addr][15:8] <= sdram_din[15:8];
      end
   end

   // read pipeline, burst sequencing, bank tracking, mode and error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdram_dout  <= 16'd0;
         sdram_dq_oe <= 2'b00;
         err         <= 1'b0;
         err_code    <= 3'd0;
         bl_code     <= 2'd0;
         cl3         <= 1'b0;
         wsingle     <= 1'b0;
         bank_open   <= 4'd0;
         act_recent  <= 4'd0;
         for (int i = 0; i < 4; i++) bank_row[i] <= '0;
         b_act       <= 1'b0;
         b_wr        <= 1'b0;
         b_ap        <= 1'b0;
         b_bank      <= 2'd0;
         b_row       <= '0;
         b_col       <= '0;
         b_k         <= 3'd0;
         b_last      <= 3'd0;
         pv          <= 2'b00;
         pa1         <= '0;
         pa2         <= '0;
         dqm_d       <= 2'b00;
      end else if (sdram_cke) begin
         // output stage and pipeline advance
         sdram_dq_oe <= pv[1] ? ~dqm_d : 2'b00;
         sdram_dout  <= pv[1] ? (mem[pa1] & {{8{~dqm_d[1]}}, {8{~dqm_d[0]}}}) : 16'd0;
         dqm_d       <= {sdram_dqmh, sdram_dqml};
         pv[1]       <= pv[2];
         pa1         <= pa2;
         pv[2]       <= 1'b0;
         if (iss && !iss_wr) begin
            if (cl3) begin
               pv[2] <= 1'b1;
               pa2   <= beat_addr;
            end else begin
               pv[1] <= 1'b1;
               pa1   <= beat_addr;
            end
         end
         // burst bookkeeping
         b_act <= iss && !iss_last;
         if (iss) begin
            b_wr   <= iss_wr;
            b_ap   <= iss_ap;
            b_bank <= iss_bank;
            b_row  <= iss_row;
            b_col  <= iss_col;
            b_k    <= iss_k + 3'd1;
            b_last <= iss_lastk;
         end
         if (iss && iss_last && iss_ap) bank_open[iss_bank] <= 1'b0;
         act_recent <= 4'd0;
         // this edge's command, applied after the beat and pipeline above
         case (cmd)
            CMD_ACT: begin
               if (bank_open[sdram_ba]) begin
                  err <= 1'b1; err_code <= 3'd2;
               end else begin
                  bank_open[sdram_ba]  <= 1'b1;
                  bank_row[sdram_ba]   <= sdram_a[ROWW-1:0];
                  act_recent[sdram_ba] <= 1'b1;
               end
            end
            CMD_RD, CMD_WR: begin
               if (!bank_open[sdram_ba]) begin
                  err <= 1'b1; err_code <= 3'd1;
               end else if (act_recent[sdram_ba]) begin
                  err <= 1'b1; err_code <= 3'd4;
               end
               // read beats still in flight collide with the write data
               if (is_wr && pv[2]) begin
                  pv    <= 2'b00;
                  err   <= 1'b1;
                  err_code <= 3'd6;
               end
            end
            CMD_PRE: begin
               if (sdram_a[10]) bank_open <= 4'd0;
               else             bank_open[sdram_ba] <= 1'b0;
            end
            CMD_REF: begin
               if (|bank_open) begin
                  err <= 1'b1; err_code <= 3'd3;
               end
            end
            CMD_MRS: begin
               if (sdram_a[2]) begin
                  err <= 1'b1; err_code <= 3'd5;
               end else begin
                  bl_code <= sdram_a[1:0];
               end
               if (sdram_a[3]) begin
                  err <= 1'b1; err_code <= 3'd5;
               end
               if (sdram_a[6:4] == 3'd2)      cl3 <= 1'b0;
               else if (sdram_a[6:4] == 3'd3) cl3 <= 1'b1;
               else begin
                  err <= 1'b1; err_code <= 3'd5;
               end
               wsingle <= sdram_a[9];
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_jtframe_sdram_responder.sv
// Self-checking bench for jtframe_sdram_responder: directed protocol steps plus
// randomized bursts against a word-level model of array, burst order and latency.
module tb_jtframe_sdram_responder;
   localparam int ROWW = 10;
   localparam int COLW = 9;

   localparam logic [2:0] C_ACT = 3'b011;
   localparam logic [2:0] C_RD  = 3'b101;
   localparam logic [2:0] C_WR  = 3'b100;
   localparam logic [2:0] C_PRE = 3'b010;
   localparam logic [2:0] C_REF = 3'b001;
   localparam logic [2:0] C_MRS = 3'b000;
   localparam logic [2:0] C_BST = 3'b110;

   logic        clk = 1'b0, rst = 1'b1, cke = 1'b1;
   logic        ncs = 1'b1, nras = 1'b1, ncas = 1'b1, nwe = 1'b1;
   logic [1:0]  ba = 2'd0;
   logic [12:0] a = 13'd0;
   logic        dqml = 1'b0, dqmh = 1'b0;
   logic [15:0] din = 16'd0;
   logic [15:0] dout;
   logic [1:0]  dq_oe;
   logic        err;
   logic [2:0]  err_code;

   always #5 clk = ~clk;

   jtframe_sdram_responder #(.ROWW(ROWW), .COLW(COLW)) dut (
      .clk(clk), .rst(rst), .sdram_cke(cke), .sdram_ncs(ncs),
      .sdram_nras(nras), .sdram_ncas(ncas), .sdram_nwe(nwe),
      .sdram_ba(ba), .sdram_a(a), .sdram_dqml(dqml), .sdram_dqmh(dqmh),
      .sdram_din(din), .sdram_dout(dout), .sdram_dq_oe(dq_oe),
      .err(err), .err_code(err_code)
   );

   int checks = 0, failures = 0;
   int cyc = 0;                          // count of enabled clock edges
   logic [15:0] mm [int];                // model array
   logic [15:0] exp_word [int];          // word visible on dout after a given edge
   logic [1:0]  dqm_hist [int];          // {dqmh,dqml} sampled at a given edge
   int m_bl = 1, m_cl = 2;
   logic [ROWW-1:0] brow [4];
   logic [15:0] wdat [8];

   function automatic int waddr(input int b, input int c);
      return (b << (ROWW + COLW)) | (int'(brow[b]) << COLW) | c;
   endfunction

   function automatic int bcol(input int c, input int k);
      return (c & ~(m_bl - 1)) | ((c + k) & (m_bl - 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
      end
   endtask

   // expected data bus after the current edge: DQM two edges before the sample point masks it
   task automatic chk_out();
      logic [1:0]  m;
      logic [17:0] e;
      e = '0;
      if (exp_word.exists(cyc)) begin
         m = dqm_hist.exists(cyc - 1) ? dqm_hist[cyc - 1] : 2'b00;
         e = {~m, exp_word[cyc][15:8] & {8{~m[1]}}, exp_word[cyc][7:0] & {8{~m[0]}}};
      end
      chk("dq_bus", {14'd0, dq_oe, dout}, {14'd0, e});
   endtask

   task automatic tick();
      @(posedge clk);
      if (cke) begin
         cyc++;
         dqm_hist[cyc] = {dqmh, dqml};
      end
      #1 chk_out();
   endtask

   task automatic nop(input int n);
      repeat (n) tick();
   endtask

   task automatic idle(input int n, input bit rnd);
      repeat (n) begin
         {dqmh, dqml} = rnd ? 2'($urandom) : 2'b00;
         tick();
      end
      {dqmh, dqml} = 2'b00;
   endtask

   task automatic cmd(input logic [2:0] c, input int b, input int av,
                      input logic [1:0] dq = 2'b00, input logic [15:0] d = 16'h0);
      ncs = 1'b0; {nras, ncas, nwe} = c; ba = b[1:0]; a = av[12:0];
      {dqmh, dqml} = dq; din = d;
      tick();
      ncs = 1'b1; {nras, ncas, nwe} = 3'b111; {dqmh, dqml} = 2'b00;
   endtask

   task automatic drop_from(input int t);
      int ks[$];
      foreach (exp_word[k]) if (k >= t) ks.push_back(k);
      foreach (ks[i]) exp_word.delete(ks[i]);
   endtask

   task automatic load_mode(input int av);
      int f;
      cmd(C_MRS, 0, av);
      if ((av & 7) < 4) m_bl = 1 << (av & 7);
      f = (av >> 4) & 7;
      if (f == 2 || f == 3) m_cl = f;
   endtask

   task automatic activate(input int b, input int r);
      cmd(C_ACT, b, r);
      brow[b] = r[ROWW-1:0];
   endtask

   task automatic fill_random();
      for (int i = 0; i < 8; i++) wdat[i] = 16'($urandom);
   endtask

   // write burst: a WRITE drops any read beats not yet on the bus
   task automatic write_burst(input int b, input int c, input bit rnd_dqm);
      for (int k = 0; k < m_bl; k++) begin
         logic [1:0] m;
         int ad;
         m  = rnd_dqm ? 2'($urandom) : 2'b00;
         ad = waddr(b, bcol(c, k));
         if (k == 0) begin
            cmd(C_WR, b, c, m, wdat[k]);
            drop_from(cyc + 1);
         end else begin
            {dqmh, dqml} = m; din = wdat[k];
            tick();
            {dqmh, dqml} = 2'b00;
         end
         if (!m[0]) mm[ad][7:0]  = wdat[k][7:0];
         if (!m[1]) mm[ad][15:8] = wdat[k][15:8];
      end
   endtask

   task automatic read_cmd(input int b, input int c, input bit ap, input logic [1:0] dq);
      int n;
      cmd(C_RD, b, c | (ap ? 1024 : 0), dq);
      n = cyc;
      for (int k = 0; k < m_bl; k++) exp_word[n + m_cl - 1 + k] = mm[waddr(b, bcol(c, k))];
   endtask

   task automatic read_full(input int b, input int c, input bit ap, input bit rnd);
      read_cmd(b, c, ap, rnd ? 2'($urandom) : 2'b00);
      idle(m_bl + m_cl, rnd);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bus", {14'd0, dq_oe, dout}, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_code", 32'(err_code), 32'd0);
      rst = 1'b0;
      nop(2);

      // CL2 BL4 write/read with wrap at the top of the burst block
      load_mode('h022);
      activate(1, 'h155);
      nop(1);
      wdat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 16'h0};
      write_burst(1, 'h1FE, 1'b0);
      chk("wr_no_err", 32'(err), 32'd0);
      read_full(1, 'h1FE, 1'b0, 1'b0);

      // CL3 with high-byte mask two edges before the second beat's sample point
      load_mode('h032);
      read_cmd(1, 'h1FE, 1'b0, 2'b00);
      tick();
      {dqmh, dqml} = 2'b10;
      tick();
      {dqmh, dqml} = 2'b00;
      nop(m_bl + m_cl);

      // protocol violations
      cmd(C_PRE, 0, 1024);
      cmd(C_RD, 2, 0);
      chk("rd_closed_err", 32'(err), 32'd1);
      chk("rd_closed_code", 32'(err_code), 32'd1);
      activate(2, 7);
      nop(1);
      cmd(C_REF, 0, 0);
      chk("ref_open_code", 32'(err_code), 32'd3);
      cmd(C_ACT, 2, 7);
      chk("act_open_code", 32'(err_code), 32'd2);
      activate(3, 9);
      fill_random();
      write_burst(3, 0, 1'b0);
      chk("trcd_code", 32'(err_code), 32'd4);

      // asynchronous reset in the middle of a read burst
      cmd(C_PRE, 0, 1024);
      activate(1, 'h155);
      nop(1);
      read_cmd(1, 'h1FE, 1'b0, 2'b00);
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      chk("async_rst_bus", {14'd0, dq_oe, dout}, 32'd0);
      chk("async_rst_err", {29'd0, err_code}, 32'd0);
      chk("async_rst_flag", 32'(err), 32'd0);
      exp_word.delete();
      dqm_hist.delete();
      m_bl = 1;
      m_cl = 2;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // array survives reset; default mode is BL1 CL2
      activate(1, 'h155);
      nop(1);
      read_full(1, 'h1FE, 1'b0, 1'b0);
      read_full(1, 'h1FD, 1'b0, 1'b0);

      // BL8 read cut by BURST TERMINATE two edges later
      load_mode('h023);
      fill_random();
      write_burst(1, 'h1F0, 1'b0);
      read_cmd(1, 'h1F3, 1'b0, 2'b00);
      tick();
      cmd(C_BST, 0, 0);
      drop_from(cyc + m_cl - 1);
      nop(10);

      // auto-precharge closes the bank after the last beat
      read_full(1, 'h1F0, 1'b1, 1'b0);
      cmd(C_RD, 1, 'h1F0);
      chk("autopre_code", 32'(err_code), 32'd1);
      nop(3);

      // clock enable low for three edges mid-burst
      activate(1, 'h155);
      nop(1);
      read_cmd(1, 'h1F0, 1'b0, 2'b00);
      nop(3);
      cke = 1'b0;
      nop(3);
      cke = 1'b1;
      nop(m_bl + m_cl);

      // illegal CAS latency keeps the previous one
      load_mode('h032);
      load_mode('h050);
      chk("bad_cl_code", 32'(err_code), 32'd5);
      read_full(1, 'h1F0, 1'b0, 1'b0);
      cmd(C_ACT, 1, 'h155);
      chk("act_open2_code", 32'(err_code), 32'd2);
      load_mode('h038);
      chk("interleave_code", 32'(err_code), 32'd5);

      // write right behind a CL3 read drops the in-flight beat
      read_cmd(1, 'h1F0, 1'b0, 2'b00);
      fill_random();
      write_burst(1, 'h1F8, 1'b0);
      chk("collision_code", 32'(err_code), 32'd6);
      nop(4);
      read_full(1, 'h1F8, 1'b0, 1'b0);

      // randomized bursts: full write, masked overwrite, masked read
      cmd(C_PRE, 0, 1024);
      for (int it = 0; it < 8; it++) begin
         int b, r, c;
         b = int'($urandom_range(0, 3));
         r = int'($urandom_range(0, (1 << ROWW) - 1));
         c = int'($urandom_range(0, (1 << COLW) - 1));
         load_mode(int'($urandom_range(0, 3)) | (int'($urandom_range(2, 3)) << 4));
         activate(b, r);
         nop(int'($urandom_range(1, 2)));
         fill_random();
         write_burst(b, c, 1'b0);
         fill_random();
         write_burst(b, c, 1'b1);
         read_full(b, c, 1'b0, 1'b1);
         cmd(C_PRE, b, 0);
      end
      chk("final_err", 32'(err), 32'd1);
      chk("final_code", 32'(err_code), 32'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
